// File: rtl/resilient_stage_sync_pkg.sv
// ---------------------------------------------------------------------------
// resilient_stage_sync_pkg
//   Shared types for the error-resilient pipeline stage.
//   - state_e : controller states (EMPTY, CHECK, STALL, FULL)
//   - sev_e   : error severity of one lane or of a whole CHECK cycle
//   - max_sev : folds one lane's short/long error flags into a severity;
//               a long-delay error always dominates a short-delay one.
// ---------------------------------------------------------------------------
package resilient_stage_sync_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    CHECK = 2'd1,
    STALL = 2'd2,
    FULL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEV_NONE = 2'd0,
    SEV_LO   = 2'd1,
    SEV_HI   = 2'd2
  } sev_e;

  function automatic sev_e max_sev(input logic err0, input logic err1);
    sev_e sev;
    sev = SEV_NONE;
    if (err1) begin
      sev = SEV_HI;
    end else if (err0) begin
      sev = SEV_LO;
    end
    return sev;
  endfunction

endpackage

// File: rtl/resilient_stage_sync_if.sv
// ---------------------------------------------------------------------------
// resilient_stage_sync_if
//   Bundles every non-clock signal of the resilient stage.
//   Left channel : l_valid, l_data (to stage), l_ready (from stage)
//   Right channel: r_ready (to stage), r_valid, r_data (from stage)
//   Error lanes  : err0/err1 (to stage), sample (from stage)
//   Status       : err_fatal, err_cnt (from stage)
//   modport master : environment side (drives the stage inputs)
//   modport slave  : the stage itself
// ---------------------------------------------------------------------------
interface resilient_stage_sync_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic             l_valid;
  logic             l_ready;
  logic [WIDTH-1:0] l_data;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic [NCH-1:0]   err0;
  logic [NCH-1:0]   err1;
  logic             sample;
  logic             err_fatal;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output l_valid, l_data, r_ready, err0, err1,
    input  l_ready, r_valid, r_data, sample, err_fatal, err_cnt
  );

  modport slave (
    input  l_valid, l_data, r_ready, err0, err1,
    output l_ready, r_valid, r_data, sample, err_fatal, err_cnt
  );
endinterface

// File: rtl/resilient_stage_sync_err_stall_timer.sv
// ---------------------------------------------------------------------------
// err_stall_timer
//   Loadable down-counter that times the stall after a failed check.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (count cleared)
//   i_load     : load i_load_val this cycle
//   i_load_val : stall length in cycles (>=1)
//   o_expire   : high during the last stall cycle (count == 1)
//   The counter parks at 0 after expiring, so o_expire is a single pulse.
// ---------------------------------------------------------------------------
module err_stall_timer #(
  parameter int STALL1 = 3,
  parameter int TW     = $clog2(STALL1 + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_expire
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == TW'(1));

endmodule

// File: rtl/resilient_stage_sync.sv
// ---------------------------------------------------------------------------
// resilient_stage_sync
//   One-token pipeline stage guarded by NCH error-detecting lanes.
//   A captured token is checked for one cycle; on an error the stage stalls
//   (STALL0 cycles for short-only errors, STALL1 if any long error), pulses
//   sample, re-captures the still-held upstream data and checks again.
//   After MAX_RETRY re-samples a failing token is forwarded anyway and the
//   sticky err_fatal flag is raised. err_cnt counts failed checks and
//   saturates.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (drops any token in flight)
//   bus   : resilient_stage_sync_if.slave (channels, error lanes, status)
// ---------------------------------------------------------------------------
module resilient_stage_sync
  import resilient_stage_sync_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NCH       = 4,
  parameter int STALL0    = 1,
  parameter int STALL1    = 3,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  resilient_stage_sync_if.slave bus
);

  localparam int TW = $clog2(STALL1 + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_data_q;
  logic [RW-1:0]    r_retry;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_fatal;

  logic             w_l_ready;
  logic             w_sample;
  logic             w_capture;
  logic             w_retry_clr;
  logic             w_retry_inc;
  logic             w_err_hit;
  logic             w_fatal_set;
  logic             w_timer_load;
  logic [TW-1:0]    w_timer_val;
  logic             w_expire;

  // Per-lane severity, then the worst one across all lanes.
  logic [NCH-1:0]   w_lane_hi;
  logic [NCH-1:0]   w_lane_lo;
  sev_e             w_sev;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    assign w_lane_hi[gi] = (max_sev(bus.err0[gi], bus.err1[gi]) == SEV_HI);
    assign w_lane_lo[gi] = (max_sev(bus.err0[gi], bus.err1[gi]) == SEV_LO);
  end

  assign w_sev = (|w_lane_hi) ? SEV_HI :
                 (|w_lane_lo) ? SEV_LO : SEV_NONE;

  err_stall_timer #(
    .STALL1 (STALL1),
    .TW     (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_l_ready    = 1'b0;
    w_sample     = 1'b0;
    w_capture    = 1'b0;
    w_retry_clr  = 1'b0;
    w_retry_inc  = 1'b0;
    w_err_hit    = 1'b0;
    w_fatal_set  = 1'b0;
    w_timer_load = 1'b0;
    w_timer_val  = TW'(STALL0);
    case (r_state)
      EMPTY: begin
        if (bus.l_valid) begin
          w_capture    = 1'b1;
          w_retry_clr  = 1'b1;
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (w_sev != SEV_NONE) begin
          w_err_hit = 1'b1;
          if (r_retry == RW'(MAX_RETRY)) begin
            // Out of retries: release upstream and forward the token as is.
            w_l_ready    = 1'b1;
            w_fatal_set  = 1'b1;
            w_state_next = FULL;
          end else begin
            w_timer_load = 1'b1;
            w_timer_val  = (w_sev == SEV_HI) ? TW'(STALL1) : TW'(STALL0);
            w_state_next = STALL;
          end
        end else begin
          w_l_ready    = 1'b1;
          w_state_next = FULL;
        end
      end
      STALL: begin
        // Upstream still holds the token (no l_ready yet), so re-capture it
        // together with the sample pulse to the detecting latches.
        if (w_expire) begin
          w_sample     = 1'b1;
          w_capture    = 1'b1;
          w_retry_inc  = 1'b1;
          w_state_next = CHECK;
        end
      end
      FULL: begin
        if (bus.r_ready) begin
          if (bus.l_valid) begin
            w_capture    = 1'b1;
            w_retry_clr  = 1'b1;
            w_state_next = CHECK;
          end else begin
            w_state_next = EMPTY;
          end
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_data_q    <= '0;
      r_retry     <= '0;
      r_err_cnt   <= '0;
      r_err_fatal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_data_q <= bus.l_data;
      end
      if (w_retry_clr) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
      if (w_err_hit && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_fatal_set) begin
        r_err_fatal <= 1'b1;
      end
    end
  end

  assign bus.l_ready   = w_l_ready;
  assign bus.sample    = w_sample;
  assign bus.r_valid   = (r_state == FULL);
  assign bus.r_data    = r_data_q;
  assign bus.err_fatal = r_err_fatal;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_resilient_stage_sync.sv
// ---------------------------------------------------------------------------
// tb_resilient_stage_sync
//   Directed bench for resilient_stage_sync: a per-cycle vector table for
//   the clean, short-error, long-error, retry-limit and back-to-back flows,
//   then hand-written sequences for err_cnt saturation and reset in STALL.
// ---------------------------------------------------------------------------
module tb_resilient_stage_sync;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mon_fail;

  resilient_stage_sync_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus();

  resilient_stage_sync #(
    .WIDTH(WIDTH), .NCH(NCH), .STALL0(1), .STALL1(3), .MAX_RETRY(2), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        rr;
    logic [3:0]  e0;
    logic [3:0]  e1;
    logic        x_lr;
    logic        x_s;
    logic        x_rv;
    logic [31:0] x_rd;
    logic [7:0]  x_cnt;
    logic        x_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lv, input logic [31:0] ld, input logic rr,
                              input logic [3:0] e0, input logic [3:0] e1,
                              input logic x_lr, input logic x_s, input logic x_rv,
                              input logic [31:0] x_rd, input logic [7:0] x_cnt,
                              input logic x_f);
    vec_t v;
    v.lv = lv; v.ld = ld; v.rr = rr; v.e0 = e0; v.e1 = e1;
    v.x_lr = x_lr; v.x_s = x_s; v.x_rv = x_rv; v.x_rd = x_rd;
    v.x_cnt = x_cnt; v.x_f = x_f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", nm, act);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " l_ready"},   32'(bus.l_ready),   32'd0);
    chk({tag, " sample"},    32'(bus.sample),    32'd0);
    chk({tag, " r_valid"},   32'(bus.r_valid),   32'd0);
    chk({tag, " r_data"},    bus.r_data,         32'd0);
    chk({tag, " err_cnt"},   32'(bus.err_cnt),   32'd0);
    chk({tag, " err_fatal"}, 32'(bus.err_fatal), 32'd0);
  endtask

  task automatic idle_inputs();
    bus.l_valid = 1'b0;
    bus.l_data  = '0;
    bus.r_ready = 1'b0;
    bus.err0    = '0;
    bus.err1    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One token through the stage with err0 held on every CHECK; bounded waits.
  task automatic send_token(input logic [31:0] d, input logic [3:0] e0);
    int n;
    bus.l_valid = 1'b1;
    bus.l_data  = d;
    bus.err0    = e0;
    n = 0;
    while (!bus.l_ready && n < 50) begin
      next_cycle();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL sat l_ready_timeout: got no l_ready within 50 cycles, required one");
    end
    next_cycle();
    bus.l_valid = 1'b0;
    bus.err0    = '0;
    n = 0;
    while (!bus.r_valid && n < 50) begin
      next_cycle();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL sat r_valid_timeout: got no r_valid within 50 cycles, required one");
    end
    bus.r_ready = 1'b1;
    next_cycle();
    bus.r_ready = 1'b0;
  endtask

  // l_ready and sample are exclusive, and both low whenever a token is held.
  always @(negedge clk) begin
    if (rst_n && bus.l_ready && bus.sample) begin
      mon_fail++;
      $display("FAIL excl: got l_ready=1 sample=1, required not both");
    end
    if (rst_n && bus.r_valid && (bus.l_ready || bus.sample)) begin
      mon_fail++;
      $display("FAIL full_quiet: got l_ready=%0b sample=%0b in FULL, required 0/0",
               bus.l_ready, bus.sample);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200us, required finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] D1 = 32'hA5A5_0001;
  localparam logic [31:0] D2 = 32'h1111_2222;
  localparam logic [31:0] D3 = 32'h3333_4444;
  localparam logic [31:0] D4 = 32'hDEAD_BEEF;
  localparam logic [31:0] D5 = 32'h0BAD_F00D;
  localparam logic [31:0] D6 = 32'h6666_0006;
  localparam logic [31:0] T1 = 32'h1000_0001;
  localparam logic [31:0] T2 = 32'h1000_0002;
  localparam logic [31:0] T3 = 32'h1000_0003;
  localparam logic [31:0] T4 = 32'h1000_0004;

  initial begin
    checks   = 0;
    failures = 0;
    mon_fail = 0;

    //          lv  ld  rr  e0       e1       lr  s  rv  rd  cnt f
    // clean token; errors in EMPTY/FULL must be ignored
    vecs.push_back(mk(1, D1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, D1, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0,  0, 4'b1111, 4'b1111, 0, 0, 1, D1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, D1, 0, 0));
    vecs.push_back(mk(0, 0,  0, 4'b1111, 4'b1111, 0, 0, 0, 0,  0, 0));
    // err0 on lane 2: one stall cycle, sample, clean re-check
    vecs.push_back(mk(1, D2, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, D2, 0, 4'b0100, 4'b0000, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(1, D2, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,  1, 0));
    vecs.push_back(mk(1, D2, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,  1, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, D2, 1, 0));
    // err0+err1 together: three stall cycles; errors during STALL ignored
    vecs.push_back(mk(1, D3, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D3, 0, 4'b0001, 4'b1000, 0, 0, 0, 0,  1, 0));
    vecs.push_back(mk(1, D3, 0, 4'b1111, 4'b1111, 0, 0, 0, 0,  2, 0));
    vecs.push_back(mk(1, D3, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  2, 0));
    vecs.push_back(mk(1, D3, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,  2, 0));
    vecs.push_back(mk(1, D3, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,  2, 0));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, D3, 2, 0));
    // three failing checks: token forwarded, err_fatal set
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  2, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0010, 4'b0000, 0, 0, 0, 0,  2, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,  3, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0001, 0, 0, 0, 0,  3, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  4, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  4, 0));
    vecs.push_back(mk(1, D4, 0, 4'b0000, 4'b0000, 0, 1, 0, 0,  4, 0));
    vecs.push_back(mk(1, D4, 0, 4'b1000, 4'b0000, 1, 0, 0, 0,  4, 0));
    vecs.push_back(mk(0, 0,  0, 4'b0000, 4'b0000, 0, 0, 1, D4, 5, 1));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, D4, 5, 1));
    // clean token afterwards keeps err_fatal
    vecs.push_back(mk(1, D5, 0, 4'b0000, 4'b0000, 0, 0, 0, 0,  5, 1));
    vecs.push_back(mk(1, D5, 0, 4'b0000, 4'b0000, 1, 0, 0, 0,  5, 1));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, D5, 5, 1));
    // back-to-back stream, then r_ready low holds the last token
    vecs.push_back(mk(1, T1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0,  5, 1));
    vecs.push_back(mk(1, T1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0,  5, 1));
    vecs.push_back(mk(1, T2, 1, 4'b0000, 4'b0000, 0, 0, 1, T1, 5, 1));
    vecs.push_back(mk(1, T2, 1, 4'b0000, 4'b0000, 1, 0, 0, 0,  5, 1));
    vecs.push_back(mk(1, T3, 1, 4'b0000, 4'b0000, 0, 0, 1, T2, 5, 1));
    vecs.push_back(mk(1, T3, 1, 4'b0000, 4'b0000, 1, 0, 0, 0,  5, 1));
    vecs.push_back(mk(1, T4, 1, 4'b0000, 4'b0000, 0, 0, 1, T3, 5, 1));
    vecs.push_back(mk(1, T4, 1, 4'b0000, 4'b0000, 1, 0, 0, 0,  5, 1));
    vecs.push_back(mk(0, 0,  0, 4'b0000, 4'b0000, 0, 0, 1, T4, 5, 1));
    vecs.push_back(mk(0, 0,  0, 4'b0000, 4'b0000, 0, 0, 1, T4, 5, 1));
    vecs.push_back(mk(0, 0,  1, 4'b0000, 4'b0000, 0, 0, 1, T4, 5, 1));
    vecs.push_back(mk(0, 0,  0, 4'b0000, 4'b0000, 0, 0, 0, 0,  5, 1));

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: inputs applied just after a rising edge, outputs checked on
    // the falling edge of the same cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      bus.l_valid = vecs[i].lv;
      bus.l_data  = vecs[i].ld;
      bus.r_ready = vecs[i].rr;
      bus.err0    = vecs[i].e0;
      bus.err1    = vecs[i].e1;
      @(negedge clk);
      chk($sformatf("v%0d l_ready", i),   32'(bus.l_ready),   32'(vecs[i].x_lr));
      chk($sformatf("v%0d sample", i),    32'(bus.sample),    32'(vecs[i].x_s));
      chk($sformatf("v%0d r_valid", i),   32'(bus.r_valid),   32'(vecs[i].x_rv));
      if (vecs[i].x_rv) begin
        chk($sformatf("v%0d r_data", i),  bus.r_data,         vecs[i].x_rd);
      end
      chk($sformatf("v%0d err_cnt", i),   32'(bus.err_cnt),   32'(vecs[i].x_cnt));
      chk($sformatf("v%0d err_fatal", i), 32'(bus.err_fatal), 32'(vecs[i].x_f));
      next_cycle();
    end
    idle_inputs();

    // Saturation: every token fails three checks; count starts at 5.
    for (int k = 1; k <= 90; k++) begin
      send_token(32'h5A00_0000 + 32'(k), 4'b0001);
      if (k == 10) chk("sat err_cnt@10", 32'(bus.err_cnt), 32'd35);
      if (k == 83) chk("sat err_cnt@83", 32'(bus.err_cnt), 32'd254);
    end
    chk("sat err_cnt@90", 32'(bus.err_cnt), 32'd255);
    chk("sat err_fatal",  32'(bus.err_fatal), 32'd1);

    // Reset asserted in the middle of a long stall.
    bus.l_valid = 1'b1;
    bus.l_data  = D6;
    bus.err1    = 4'b0100;
    next_cycle();                 // now in CHECK with err1
    next_cycle();                 // now in first STALL cycle
    bus.err1    = '0;
    chk("rst6 pre sample", 32'(bus.sample), 32'd0);
    rst_n       = 1'b0;
    bus.l_valid = 1'b0;
    #1;
    chk_all_zero("rst6 during");
    repeat (3) begin
      @(negedge clk);
      chk("rst6 held sample", 32'(bus.sample), 32'd0);
    end
    next_cycle();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst6 dropped r_valid", 32'(bus.r_valid), 32'd0);
      chk("rst6 dropped sample",  32'(bus.sample),  32'd0);
    end
    next_cycle();
    bus.l_valid = 1'b1;
    bus.l_data  = D6;
    @(negedge clk);
    chk("rst6 l_ready@0", 32'(bus.l_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst6 l_ready@1", 32'(bus.l_ready), 32'd1);
    next_cycle();
    bus.l_valid = 1'b0;
    @(negedge clk);
    chk("rst6 r_valid@2",  32'(bus.r_valid),   32'd1);
    chk("rst6 r_data",     bus.r_data,         D6);
    chk("rst6 err_cnt",    32'(bus.err_cnt),   32'd0);
    chk("rst6 err_fatal",  32'(bus.err_fatal), 32'd0);
    next_cycle();
    bus.r_ready = 1'b1;
    next_cycle();
    bus.r_ready = 1'b0;
    @(negedge clk);
    chk("rst6 drained r_valid", 32'(bus.r_valid), 32'd0);

    // Fold in the continuous handshake monitor.
    chk("monitor violations", 32'(mon_fail), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
